// File: rtl/program_loader.sv
// Boot-time image loader: assembles a framed little-endian byte stream into the
// core's instruction-memory image and releases core reset once the checksum verifies.
module program_loader #(
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic [DEPTH-1:0][31:0] mem_out,
  output logic [8:0]             words_loaded,
  output logic                   load_done,
  output logic                   load_error,
  output logic                   cpu_rst_n
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR
  } state_t;

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] frame_len;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [7:0]  checksum;
  logic [31:0] to_cnt;

  logic        accept;
  logic [15:0] len_word;
  logic [15:0] next_count;
  logic        timeout_hit;

  assign accept      = in_valid & in_ready;
  assign len_word    = {in_data, len_lo};
  assign next_count  = 16'(words_loaded) + 16'd1;
  assign timeout_hit = (TIMEOUT != 0) && (to_cnt + 32'd1 == 32'(TIMEOUT));

  // in_ready tracks the state register: it is set on every edge that enters
  // LEN_LO and cleared on every edge that leaves CHECK or aborts a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the image array is part of the async reset on purpose; a reset
      // mid-frame must leave no stale or partial program behind for the core.
      state        <= IDLE;
      in_ready     <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      cpu_rst_n    <= 1'b0;
      words_loaded <= '0;
      mem_out      <= '0;
      len_lo       <= '0;
      frame_len    <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      checksum     <= '0;
      to_cnt       <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples the pre-edge values, regardless of statement order.
      unique case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state        <= LEN_LO;
            in_ready     <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            cpu_rst_n    <= 1'b0;
            words_loaded <= '0;
            byte_idx     <= '0;
            checksum     <= '0;
            to_cnt       <= '0;
          end
        end
        default: begin
          if (accept) begin
            to_cnt <= '0;
            case (state)
              LEN_LO: begin
                len_lo <= in_data;
                state  <= LEN_HI;
              end
              LEN_HI: begin
                frame_len <= len_word;
                if (len_word == 16'd0 || len_word > 16'(DEPTH)) begin
                  state      <= ERROR;
                  in_ready   <= 1'b0;
                  load_error <= 1'b1;
                end else begin
                  state <= DATA;
                end
              end
              DATA: begin
                checksum <= checksum ^ in_data;
                if (byte_idx == 2'd3) begin
                  mem_out[words_loaded[AW-1:0]] <= {in_data, word_buf};
                  words_loaded <= words_loaded + 9'd1;
                  byte_idx     <= '0;
                  if (next_count == frame_len) state <= CHECK;
                end else begin
                  word_buf[{byte_idx, 3'b000} +: 8] <= in_data;
                  byte_idx <= byte_idx + 2'd1;
                end
              end
              CHECK: begin
                in_ready <= 1'b0;
                if (in_data == checksum) begin
                  state     <= DONE;
                  load_done <= 1'b1;
                  cpu_rst_n <= 1'b1;
                end else begin
                  state      <= ERROR;
                  load_error <= 1'b1;
                end
              end
              default: ;
            endcase
          end else if (timeout_hit) begin
            state      <= ERROR;
            in_ready   <= 1'b0;
            load_error <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framing, checksum, length limits, timeout,
// full-image load with stalls, and asynchronous reset mid-frame.
module tb_program_loader;

  localparam int DEPTH   = 256;
  localparam int TIMEOUT = 10;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   start = 1'b0;
  logic                   in_valid = 1'b0;
  logic [7:0]             in_data = 8'h00;
  logic                   in_ready;
  logic [DEPTH-1:0][31:0] mem_out;
  logic [8:0]             words_loaded;
  logic                   load_done;
  logic                   load_error;
  logic                   cpu_rst_n;

  int checks = 0;
  int errors = 0;

  program_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_out      (mem_out),
    .words_loaded (words_loaded),
    .load_done    (load_done),
    .load_error   (load_error),
    .cpu_rst_n    (cpu_rst_n)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one byte after 'gap' idle cycles and holds it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    for (int g = 0; g < gap; g++) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake: in_ready=%0b while sending %02h, required 1", in_ready, b);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, load_done, load_error, cpu_rst_n} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: ready/done/err/cpu=%b, required 0000",
               {in_ready, load_done, load_error, cpu_rst_n});
    end
    checks++;
    if (words_loaded !== 9'd0 || mem_out !== '0) begin
      errors++;
      $display("FAIL reset_state: words_loaded=%0d mem nonzero=%0b, required 0 and 0",
               words_loaded, |mem_out);
    end
    rst = 1'b1;
  endtask

  task automatic test_single_word();
    pulse_start();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: in_ready=%0b, required 1", in_ready);
    end
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h93, 0);
    send_byte(8'h03, 0);
    send_byte(8'h50, 0);
    send_byte(8'h00, 0);
    checks++;
    if (load_done !== 1'b0 || words_loaded !== 9'd1) begin
      errors++;
      $display("FAIL pre_checksum: load_done=%0b words_loaded=%0d, required 0 and 1",
               load_done, words_loaded);
    end
    send_byte(8'hC0, 0);
    checks++;
    if ({load_done, cpu_rst_n, in_ready, load_error} !== 4'b1100) begin
      errors++;
      $display("FAIL single_done: done/cpu/ready/err=%b, required 1100",
               {load_done, cpu_rst_n, in_ready, load_error});
    end
    checks++;
    if (mem_out[0] !== 32'h00500393) begin
      errors++;
      $display("FAIL single_word: mem_out[0]=%08h, required 00500393", mem_out[0]);
    end
  endtask

  task automatic test_bad_checksum();
    pulse_start();
    checks++;
    if ({load_done, cpu_rst_n, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL restart_from_done: done/cpu/ready=%b, required 001",
               {load_done, cpu_rst_n, in_ready});
    end
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h93, 0);
    send_byte(8'h03, 0);
    send_byte(8'h50, 0);
    send_byte(8'h00, 0);
    send_byte(8'hC1, 0);
    checks++;
    if ({load_error, cpu_rst_n, load_done, in_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL bad_checksum: err/cpu/done/ready=%b, required 1000",
               {load_error, cpu_rst_n, load_done, in_ready});
    end
    checks++;
    if (mem_out[0] !== 32'h00500393) begin
      errors++;
      $display("FAIL bad_checksum_mem: mem_out[0]=%08h, required 00500393", mem_out[0]);
    end
  endtask

  task automatic test_bad_length();
    pulse_start();
    checks++;
    if (load_error !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_from_error: load_error=%0b in_ready=%0b, required 0 and 1",
               load_error, in_ready);
    end
    send_byte(8'h00, 0);
    checks++;
    if (load_error !== 1'b0) begin
      errors++;
      $display("FAIL len_zero_early: load_error=%0b, required 0", load_error);
    end
    send_byte(8'h00, 0);
    checks++;
    if (load_error !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL len_zero: load_error=%0b in_ready=%0b, required 1 and 0",
               load_error, in_ready);
    end
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    checks++;
    if (load_error !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL len_257: load_error=%0b in_ready=%0b, required 1 and 0",
               load_error, in_ready);
    end
  endtask

  task automatic test_full_image();
    logic [7:0] cs;
    logic [31:0] w;
    int bad;
    cs = 8'h00;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 1);
    for (int i = 0; i < DEPTH; i++) begin
      w = 32'(i);
      for (int k = 0; k < 4; k++) begin
        cs = cs ^ w[8*k +: 8];
        send_byte(w[8*k +: 8], int'($urandom_range(0, 3)));
      end
    end
    send_byte(cs, 2);
    checks++;
    if (load_done !== 1'b1 || cpu_rst_n !== 1'b1 || words_loaded !== 9'd256) begin
      errors++;
      $display("FAIL full_done: load_done=%0b cpu_rst_n=%0b words_loaded=%0d, required 1 1 256",
               load_done, cpu_rst_n, words_loaded);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (mem_out[i] !== 32'(i)) begin
        errors++;
        bad++;
        if (bad <= 4)
          $display("FAIL full_word: mem_out[%0d]=%08h, required %08h", i, mem_out[i], 32'(i));
      end
    end
  endtask

  task automatic test_timeout_reload();
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(posedge clk);
      #1;
      if (k == TIMEOUT - 1) begin
        checks++;
        if (load_error !== 1'b0) begin
          errors++;
          $display("FAIL timeout_early: load_error=%0b after %0d idle cycles, required 0",
                   load_error, k);
        end
      end
    end
    checks++;
    if (load_error !== 1'b1 || in_ready !== 1'b0 || cpu_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL timeout: err/ready/cpu=%b after %0d idle cycles, required 100",
               {load_error, in_ready, cpu_rst_n}, TIMEOUT);
    end
    checks++;
    if (mem_out[0] !== 32'h0 || mem_out[1] !== 32'h1) begin
      errors++;
      $display("FAIL timeout_mem: mem_out[0]=%08h mem_out[1]=%08h, required 00000000 00000001",
               mem_out[0], mem_out[1]);
    end
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    pulse_start();  // must be ignored mid-frame
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hDE, 0);
    send_byte(8'h22, 0);
    checks++;
    if (load_done !== 1'b1 || mem_out[0] !== 32'hDEADBEEF || words_loaded !== 9'd1) begin
      errors++;
      $display("FAIL reload: load_done=%0b mem_out[0]=%08h words_loaded=%0d, required 1 DEADBEEF 1",
               load_done, mem_out[0], words_loaded);
    end
    checks++;
    if (mem_out[1] !== 32'h1) begin
      errors++;
      $display("FAIL reload_untouched: mem_out[1]=%08h, required 00000001", mem_out[1]);
    end
  endtask

  task automatic test_reset_mid_frame();
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    checks++;
    if (words_loaded !== 9'd1 || mem_out[0] !== 32'h44332211) begin
      errors++;
      $display("FAIL mid_frame: words_loaded=%0d mem_out[0]=%08h, required 1 44332211",
               words_loaded, mem_out[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, load_done, load_error, cpu_rst_n} !== 4'b0000 || words_loaded !== 9'd0) begin
      errors++;
      $display("FAIL async_reset: ready/done/err/cpu=%b words_loaded=%0d, required 0000 0",
               {in_ready, load_done, load_error, cpu_rst_n}, words_loaded);
    end
    checks++;
    if (mem_out !== '0) begin
      errors++;
      $display("FAIL async_reset_mem: mem_out[0]=%08h mem_out[255]=%08h, required all zero",
               mem_out[0], mem_out[255]);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_start_collision();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h05;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h44, 0);
    checks++;
    if (load_done !== 1'b1 || load_error !== 1'b0 || mem_out[0] !== 32'h44332211) begin
      errors++;
      $display("FAIL start_collision: done=%0b err=%0b mem_out[0]=%08h, required 1 0 44332211",
               load_done, load_error, mem_out[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_bad_checksum();
    test_bad_length();
    test_full_image();
    test_timeout_reload();
    test_reset_mid_frame();
    test_start_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
